// File: rtl/risc_pkg.sv
// risc_pkg: constants shared by the write-back / register-file slice.
//   DATA_W, ADDR_W : default datapath and register-address widths.
//   MD_*           : MuxD select encoding used by the write-back stage.
package risc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] MD_FUNC = 2'd0;  // function-unit result
  localparam logic [1:0] MD_DATA = 2'd1;  // data-memory read data
  localparam logic [1:0] MD_SLT  = 2'd2;  // zero-extended N xor V flag
  localparam logic [1:0] MD_ZERO = 2'd3;  // constant zero

endpackage

// File: rtl/regfile_core.sv
// regfile_core: 2^ADDR_W x DATA_W architectural register file.
//   clk     in  : write clock, rising edge
//   rst_n   in  : asynchronous active-low clear of every register
//   we      in  : write enable
//   wa      in  : write address (address 0 is never written)
//   d_data  in  : write data
//   aa, ba  in  : read addresses for ports A and B
//   a_data  out : combinational contents of register aa (0 for R0)
//   b_data  out : combinational contents of register ba (0 for R0)
module regfile_core
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int ADDR_W = risc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ADDR_W-1:0] aa,
  input  logic [ADDR_W-1:0] ba,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];

  // Reset clears the array at once; a write on the same edge is simply lost
  // because the reset branch takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= d_data;
    end
  end

  // No write-to-read bypass: reads see the array as it stands, so a write
  // becomes visible only after its clock edge. R0 is forced to zero.
  assign a_data = (aa == '0) ? '0 : mem[aa];
  assign b_data = (ba == '0) ? '0 : mem[ba];

endmodule

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: write-back stage fused with the register file.
//   CLK      in  : clock, state updates on the rising edge
//   reset    in  : asynchronous active-low reset of the register file
//   MD_1     in  : MuxD select (MD_FUNC / MD_DATA / MD_SLT / MD_ZERO)
//   NxorV    in  : signed less-than flag from execute
//   FUNC_OUT in  : function-unit result
//   DATA_OUT in  : data-memory read data
//   RW_1     in  : register write enable
//   DA_1     in  : destination register address
//   AA, BA   in  : read port addresses
//   Bus_D    out : selected write-back value (combinational, unaffected by reset)
//   A_Data   out : contents of register AA (combinational)
//   B_Data   out : contents of register BA (combinational)
module wb_regfile_stage
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int ADDR_W = risc_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        MD_1,
  input  logic              NxorV,
  input  logic [DATA_W-1:0] FUNC_OUT,
  input  logic [DATA_W-1:0] DATA_OUT,
  input  logic              RW_1,
  input  logic [ADDR_W-1:0] DA_1,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] Bus_D,
  output logic [DATA_W-1:0] A_Data,
  output logic [DATA_W-1:0] B_Data
);

  // MuxD: picks the value to commit this cycle.
  always_comb begin
    Bus_D = '0;
    case (MD_1)
      MD_FUNC: Bus_D = FUNC_OUT;
      MD_DATA: Bus_D = DATA_OUT;
      MD_SLT:  Bus_D = {{(DATA_W-1){1'b0}}, NxorV};
      default: Bus_D = '0;
    endcase
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile_core (
    .clk    (CLK),
    .rst_n  (reset),
    .we     (RW_1),
    .wa     (DA_1),
    .d_data (Bus_D),
    .aa     (AA),
    .ba     (BA),
    .a_data (A_Data),
    .b_data (B_Data)
  );

endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb_wb_regfile_stage: directed and randomized checks of wb_regfile_stage
// against a behavioural model (array of registers + select table).
module tb_wb_regfile_stage;

  logic        CLK;
  logic        reset;
  logic [1:0]  MD_1;
  logic        NxorV;
  logic [31:0] FUNC_OUT;
  logic [31:0] DATA_OUT;
  logic        RW_1;
  logic [4:0]  DA_1;
  logic [4:0]  AA;
  logic [4:0]  BA;
  logic [31:0] Bus_D;
  logic [31:0] A_Data;
  logic [31:0] B_Data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  wb_regfile_stage dut (
    .CLK      (CLK),
    .reset    (reset),
    .MD_1     (MD_1),
    .NxorV    (NxorV),
    .FUNC_OUT (FUNC_OUT),
    .DATA_OUT (DATA_OUT),
    .RW_1     (RW_1),
    .DA_1     (DA_1),
    .AA       (AA),
    .BA       (BA),
    .Bus_D    (Bus_D),
    .A_Data   (A_Data),
    .B_Data   (B_Data)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected committed value straight from the select table.
  function automatic logic [31:0] exp_mux(input logic [1:0] md, input logic nv,
                                          input logic [31:0] fo, input logic [31:0] dm);
    case (md)
      2'd0:    return fo;
      2'd1:    return dm;
      2'd2:    return nv ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive at the falling edge, check combinational
  // outputs before the rising edge (old register contents), apply the model
  // write at the rising edge, then check reads again just after it.
  task automatic step(input string tag, input logic [1:0] md, input logic nv,
                      input logic [31:0] fo, input logic [31:0] dm, input logic rw,
                      input logic [4:0] da, input logic [4:0] a, input logic [4:0] b);
    logic [31:0] eb;
    @(negedge CLK);
    MD_1 = md; NxorV = nv; FUNC_OUT = fo; DATA_OUT = dm;
    RW_1 = rw; DA_1 = da; AA = a; BA = b;
    eb = exp_mux(md, nv, fo, dm);
    #1;
    check({tag, "_bus"}, Bus_D, eb);
    check({tag, "_a_pre"}, A_Data, exp_rd(a));
    check({tag, "_b_pre"}, B_Data, exp_rd(b));
    @(posedge CLK);
    if (reset && rw && da != 5'd0) model[da] = eb;
    #1;
    check({tag, "_a_post"}, A_Data, exp_rd(a));
    check({tag, "_b_post"}, B_Data, exp_rd(b));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reset = 1'b0; MD_1 = 2'd0; NxorV = 1'b0; FUNC_OUT = '0; DATA_OUT = '0;
    RW_1 = 1'b0; DA_1 = '0; AA = '0; BA = '0;

    // Reset hold: writes blocked, Bus_D still live.
    for (int k = 0; k < 3; k++)
      step("rst_hold", 2'd1, 1'b0, 32'h0, 32'hFECDA097, 1'b1, 5'd5, 5'd5, 5'd31);

    // Release between edges; first edge after release carries no write.
    reset = 1'b1;
    step("mux_nowr", 2'd0, 1'b0, 32'h45A0F123, 32'hAA999AFE, 1'b0, 5'd22, 5'd22, 5'd23);

    // Memory data write-back; pre-edge read must still be 0.
    step("wb_mem", 2'd1, 1'b0, 32'h45A0F123, 32'hFECDA097, 1'b1, 5'd5, 5'd5, 5'd5);

    // SLT path and zero select.
    step("slt_one", 2'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd7, 5'd5, 5'd7);
    step("slt_zero", 2'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd7, 5'd7, 5'd7);
    step("md_zero", 2'd3, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 5'd9, 5'd7, 5'd5);

    // R0 protection.
    step("r0_prot", 2'd0, 1'b0, 32'h09A0FFF3, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++)
      step("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Async reset between edges: R5 must clear before the next rising edge.
    step("r5_set", 2'd1, 1'b0, 32'h0, 32'hFECDA097, 1'b1, 5'd5, 5'd5, 5'd7);
    @(negedge CLK);
    RW_1 = 1'b0; AA = 5'd5; BA = 5'd5;
    #1;
    check("r5_before_rst", A_Data, 32'hFECDA097);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    check("async_clr_a", A_Data, 32'd0);
    check("async_clr_b", B_Data, 32'd0);
    check("async_bus", Bus_D, 32'hFECDA097);

    // Writes stay blocked while held in reset.
    step("rst_blk", 2'd0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, 5'd12, 5'd12, 5'd5);
    reset = 1'b1;
    step("rel_nowr", 2'd0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 5'd12, 5'd12, 5'd12);
    step("rel_wr", 2'd0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 5'd12, 5'd12, 5'd12);
    step("rel_rd", 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
